csr_trap_ctrl: RTL and testbench

Machine-mode trap sequencer that drives the CSR file's secondary (trap) read/write port. It detects ECALL, EBREAK and MRET in the execute stage, and pending asynchronous interrupts. For each trap it stalls the pipeline, writes the trap CSRs one per cycle, then issues a single-cycle redirect to the trap vector or to the return address.

---
 rtl/csr_trap_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_csr_trap_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_trap_ctrl.sv
// ---------------------------------------------------------------------------
// csr_trap_ctrl
//
// Machine-mode trap sequencer. Detects ECALL / EBREAK / MRET in the execute
// stage and pending asynchronous interrupts. For each trap it stalls the
// pipeline, writes the trap CSRs through the CSR file's secondary port one
// per cycle, then issues a single-cycle redirect.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   inst_i, inst_addr_i execute-stage instruction and its PC
//   jump_flag_i/addr_i  execute-stage branch/jump being taken and its target
//   hold_flag_i         pipeline already held elsewhere (does not block us)
//   div_started_i       multi-cycle divide in flight (blocks async entry)
//   int_flag_i          level interrupt requests, bit0 = timer
//   global_int_en_i     mstatus.MIE
//   csr_mtvec_i, csr_mepc_i, csr_mstatus_i  current CSR values
//   we_o, waddr_o, data_o   CSR write port
//   raddr_o             CSR read address, always 0
//   hold_flag_o         stall request
//   int_assert_o        one-cycle redirect strobe, target on int_addr_o
// ---------------------------------------------------------------------------
module csr_trap_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_i,
  input  logic [31:0] inst_addr_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_flag_i,
  input  logic        div_started_i,
  input  logic [7:0]  int_flag_i,
  input  logic        global_int_en_i,
  input  logic [31:0] csr_mtvec_i,
  input  logic [31:0] csr_mepc_i,
  input  logic [31:0] csr_mstatus_i,
  output logic        we_o,
  output logic [31:0] waddr_o,
  output logic [31:0] raddr_o,
  output logic [31:0] data_o,
  output logic        hold_flag_o,
  output logic        int_assert_o,
  output logic [31:0] int_addr_o
);

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  localparam logic [31:0] CSR_MSTATUS = 32'h0000_0300;
  localparam logic [31:0] CSR_MEPC    = 32'h0000_0341;
  localparam logic [31:0] CSR_MCAUSE  = 32'h0000_0342;

  localparam logic [31:0] CAUSE_ECALL  = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK = 32'd3;
  localparam logic [31:0] CAUSE_TIMER  = 32'h8000_0007;
  localparam logic [31:0] CAUSE_EXT    = 32'h8000_000B;

  typedef enum logic [1:0] {
    T_IDLE,
    T_SYNC,
    T_ASYNC,
    T_MRET
  } trap_state_t;

  typedef enum logic [2:0] {
    C_IDLE,
    C_MEPC,
    C_MSTATUS,
    C_MCAUSE,
    C_MRET_MSTATUS,
    C_ASSERT
  } csr_state_t;

  trap_state_t trap_state_reg, trap_state_next;
  csr_state_t  csr_state_reg,  csr_state_next;
  logic [31:0] cause_reg, cause_next;
  logic [31:0] epc_reg,   epc_next;

  logic is_ecall, is_ebreak, is_mret, is_sync;
  logic idle;
  logic det_sync, det_mret, det_async, det_any;

  // hold_flag_i is deliberately not part of detection; it only concerns the
  // pipeline controller.
  logic unused_hold;
  assign unused_hold = hold_flag_i;

  assign is_ecall  = (inst_i == INST_ECALL);
  assign is_ebreak = (inst_i == INST_EBREAK);
  assign is_mret   = (inst_i == INST_MRET);
  assign is_sync   = is_ecall | is_ebreak;

  assign idle = (trap_state_reg == T_IDLE) && (csr_state_reg == C_IDLE);

  // Detection is suppressed while rst is high so every output reads 0 in reset.
  assign det_sync  = !rst && idle && is_sync;
  assign det_mret  = !rst && idle && is_mret;
  assign det_async = !rst && idle && !is_sync && !is_mret &&
                     (int_flag_i != 8'd0) && global_int_en_i && !div_started_i;
  assign det_any   = det_sync | det_mret | det_async;

  // -------------------------------------------------------------------------
  // Next-state logic for both FSMs and the latched cause/epc.
  // -------------------------------------------------------------------------
  always_comb begin
    trap_state_next = trap_state_reg;
    csr_state_next  = csr_state_reg;
    cause_next      = cause_reg;
    epc_next        = epc_reg;

    case (csr_state_reg)
      C_IDLE: begin
        if (det_sync) begin
          trap_state_next = T_SYNC;
          csr_state_next  = C_MEPC;
          cause_next      = is_ecall ? CAUSE_ECALL : CAUSE_EBREAK;
          epc_next        = inst_addr_i;
        end else if (det_mret) begin
          trap_state_next = T_MRET;
          csr_state_next  = C_MRET_MSTATUS;
        end else if (det_async) begin
          trap_state_next = T_ASYNC;
          csr_state_next  = C_MEPC;
          cause_next      = int_flag_i[0] ? CAUSE_TIMER : CAUSE_EXT;
          // A jump in execute means the interrupted flow continues at its target.
          epc_next        = jump_flag_i ? jump_addr_i : inst_addr_i;
        end
      end
      C_MEPC:         csr_state_next = C_MSTATUS;
      C_MSTATUS:      csr_state_next = C_MCAUSE;
      C_MCAUSE:       csr_state_next = C_ASSERT;
      C_MRET_MSTATUS: csr_state_next = C_ASSERT;
      C_ASSERT: begin
        csr_state_next  = C_IDLE;
        trap_state_next = T_IDLE;
      end
      default: begin
        csr_state_next  = C_IDLE;
        trap_state_next = T_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs. Everything is forced to 0 while rst is high so that a reset
  // landing mid-sequence produces no further write, even in its own cycle.
  // -------------------------------------------------------------------------
  always_comb begin
    we_o         = 1'b0;
    waddr_o      = 32'd0;
    raddr_o      = 32'd0;
    data_o       = 32'd0;
    hold_flag_o  = 1'b0;
    int_assert_o = 1'b0;
    int_addr_o   = 32'd0;

    if (!rst) begin
      hold_flag_o = det_any || (csr_state_reg != C_IDLE);

      case (csr_state_reg)
        C_MEPC: begin
          we_o    = 1'b1;
          waddr_o = CSR_MEPC;
          data_o  = epc_reg;
        end
        C_MSTATUS: begin
          // MPIE <= MIE, MIE <= 0
          we_o    = 1'b1;
          waddr_o = CSR_MSTATUS;
          data_o  = {csr_mstatus_i[31:8], csr_mstatus_i[3],
                     csr_mstatus_i[6:4], 1'b0, csr_mstatus_i[2:0]};
        end
        C_MCAUSE: begin
          we_o    = 1'b1;
          waddr_o = CSR_MCAUSE;
          data_o  = cause_reg;
        end
        C_MRET_MSTATUS: begin
          // MIE <= MPIE, MPIE <= 1
          we_o    = 1'b1;
          waddr_o = CSR_MSTATUS;
          data_o  = {csr_mstatus_i[31:8], 1'b1,
                     csr_mstatus_i[6:4], csr_mstatus_i[7], csr_mstatus_i[2:0]};
        end
        C_ASSERT: begin
          int_assert_o = 1'b1;
          int_addr_o   = (trap_state_reg == T_MRET) ? csr_mepc_i : csr_mtvec_i;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trap_state_reg <= T_IDLE;
      csr_state_reg  <= C_IDLE;
      cause_reg      <= 32'd0;
      epc_reg        <= 32'd0;
    end else begin
      trap_state_reg <= trap_state_next;
      csr_state_reg  <= csr_state_next;
      cause_reg      <= cause_next;
      epc_reg        <= epc_next;
    end
  end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// ---------------------------------------------------------------------------
// tb_csr_trap_ctrl
//
// Scoreboard bench: each stimulus pushes the CSR writes / redirect it should
// cause (with the cycle they must appear in); a negedge monitor pops and
// compares every write or redirect the DUT produces.
// ---------------------------------------------------------------------------
module tb_csr_trap_ctrl;

  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] MRET   = 32'h3020_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_i, inst_addr_i, jump_addr_i;
  logic        jump_flag_i, hold_flag_i, div_started_i, global_int_en_i;
  logic [7:0]  int_flag_i;
  logic [31:0] csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
  logic        we_o, hold_flag_o, int_assert_o;
  logic [31:0] waddr_o, raddr_o, data_o, int_addr_o;

  typedef struct {
    logic        is_assert;
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  n_cmp = 0;
  int  n_bad = 0;

  csr_trap_ctrl dut (
    .clk(clk), .rst(rst),
    .inst_i(inst_i), .inst_addr_i(inst_addr_i),
    .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .hold_flag_i(hold_flag_i), .div_started_i(div_started_i),
    .int_flag_i(int_flag_i), .global_int_en_i(global_int_en_i),
    .csr_mtvec_i(csr_mtvec_i), .csr_mepc_i(csr_mepc_i), .csr_mstatus_i(csr_mstatus_i),
    .we_o(we_o), .waddr_o(waddr_o), .raddr_o(raddr_o), .data_o(data_o),
    .hold_flag_o(hold_flag_o), .int_assert_o(int_assert_o), .int_addr_o(int_addr_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_wr(input logic [31:0] addr, input logic [31:0] data, input int c);
    ev_t e;
    e.is_assert = 1'b0; e.addr = addr; e.data = data; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic push_as(input logic [31:0] target, input int c);
    ev_t e;
    e.is_assert = 1'b1; e.addr = target; e.data = 32'd0; e.cyc = c;
    exp_q.push_back(e);
  endtask

  // Monitor: every write or redirect must match the head of the scoreboard.
  always @(negedge clk) begin
    if (we_o || int_assert_o) begin
      ev_t e;
      if (we_o && int_assert_o) check("we_and_assert_same_cycle", 32'd1, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_event", {waddr_o[15:0], 15'd0, int_assert_o}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("ev_cycle", cyc, e.cyc);
        check("ev_kind", {31'd0, int_assert_o}, {31'd0, e.is_assert});
        if (e.is_assert) begin
          check("int_addr", int_addr_o, e.addr);
        end else begin
          check("waddr", waddr_o, e.addr);
          check("wdata", data_o, e.data);
        end
        $display("event cyc=%0d we=%0b waddr=%h data=%h assert=%0b addr=%h",
                 cyc, we_o, waddr_o, data_o, int_assert_o, int_addr_o);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  // Drive the detect cycle, check hold during detect and the 4 busy cycles,
  // then confirm hold drops. Instruction/interrupt inputs are cleared after detect.
  task automatic run_seq(input string tag, input int busy);
    settle();
    check({tag, "_hold_detect"}, {31'd0, hold_flag_o}, 32'd1);
    step();
    inst_i = NOP; int_flag_i = 8'd0; jump_flag_i = 1'b0;
    for (int i = 0; i < busy; i++) begin
      settle();
      check({tag, "_hold_busy"}, {31'd0, hold_flag_o}, 32'd1);
      step();
    end
    settle();
    check({tag, "_hold_done"}, {31'd0, hold_flag_o}, 32'd0);
    step();
  endtask

  initial begin
    int d;
    rst = 1'b1;
    inst_i = ECALL; inst_addr_i = 32'h0; jump_flag_i = 1'b0; jump_addr_i = 32'h0;
    hold_flag_i = 1'b0; div_started_i = 1'b0; int_flag_i = 8'h01; global_int_en_i = 1'b1;
    csr_mtvec_i = 32'h200; csr_mepc_i = 32'h0; csr_mstatus_i = 32'h8;
    repeat (3) step();
    settle();
    check("rst_we", {31'd0, we_o}, 32'd0);
    check("rst_hold", {31'd0, hold_flag_o}, 32'd0);
    check("rst_assert", {31'd0, int_assert_o}, 32'd0);
    check("rst_waddr", waddr_o, 32'd0);
    check("rst_data", data_o, 32'd0);
    check("rst_int_addr", int_addr_o, 32'd0);
    step();
    inst_i = NOP; int_flag_i = 8'd0;
    rst = 1'b0;
    step();

    // ECALL, with an unrelated pipeline hold present
    hold_flag_i = 1'b1;
    inst_i = ECALL; inst_addr_i = 32'h100; csr_mtvec_i = 32'h200; csr_mstatus_i = 32'h8;
    d = cyc;
    push_wr(32'h341, 32'h100, d + 1);
    push_wr(32'h300, 32'h80, d + 2);
    push_wr(32'h342, 32'd11, d + 3);
    push_as(32'h200, d + 4);
    run_seq("ecall", 4);
    hold_flag_i = 1'b0;
    settle();
    check("raddr_zero", raddr_o, 32'd0);
    step();

    // MRET
    inst_i = MRET; inst_addr_i = 32'h400; csr_mstatus_i = 32'h80; csr_mepc_i = 32'h104;
    d = cyc;
    push_wr(32'h300, 32'h88, d + 1);
    push_as(32'h104, d + 2);
    run_seq("mret", 2);

    // timer interrupt while execute is jumping
    csr_mstatus_i = 32'h8; csr_mtvec_i = 32'h240;
    int_flag_i = 8'h01; global_int_en_i = 1'b1; jump_flag_i = 1'b1;
    jump_addr_i = 32'h300; inst_addr_i = 32'h1a0;
    d = cyc;
    push_wr(32'h341, 32'h300, d + 1);
    push_wr(32'h300, 32'h80, d + 2);
    push_wr(32'h342, 32'h8000_0007, d + 3);
    push_as(32'h240, d + 4);
    run_seq("irq_timer", 4);

    // external interrupt, no jump
    int_flag_i = 8'h04; inst_addr_i = 32'h1c4; csr_mstatus_i = 32'h88;
    d = cyc;
    push_wr(32'h341, 32'h1c4, d + 1);
    push_wr(32'h300, 32'h80, d + 2);
    push_wr(32'h342, 32'h8000_000B, d + 3);
    push_as(32'h240, d + 4);
    run_seq("irq_ext", 4);

    // masked interrupt: no hold, no write (monitor flags any write)
    int_flag_i = 8'h01; global_int_en_i = 1'b0;
    settle();
    check("masked_hold", {31'd0, hold_flag_o}, 32'd0);
    step(); step();
    global_int_en_i = 1'b1; div_started_i = 1'b1;
    settle();
    check("div_hold", {31'd0, hold_flag_o}, 32'd0);
    step(); step();
    div_started_i = 1'b0;

    // EBREAK beats a pending interrupt; the interrupt stays requested but ignored
    inst_i = EBREAK; inst_addr_i = 32'h208; csr_mstatus_i = 32'h8; int_flag_i = 8'h01;
    d = cyc;
    push_wr(32'h341, 32'h208, d + 1);
    push_wr(32'h300, 32'h80, d + 2);
    push_wr(32'h342, 32'd3, d + 3);
    push_as(32'h240, d + 4);
    settle();
    check("ebreak_hold_detect", {31'd0, hold_flag_o}, 32'd1);
    step();
    inst_i = NOP;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) int_flag_i = 8'd0;
      settle();
      check("ebreak_hold_busy", {31'd0, hold_flag_o}, 32'd1);
      step();
    end
    settle();
    check("ebreak_hold_done", {31'd0, hold_flag_o}, 32'd0);
    step();

    // reset during the mstatus write: only mepc is written
    inst_i = ECALL; inst_addr_i = 32'h120;
    d = cyc;
    push_wr(32'h341, 32'h120, d + 1);
    step();
    inst_i = NOP;
    step();
    rst = 1'b1;
    settle();
    check("rst_mid_we", {31'd0, we_o}, 32'd0);
    step();
    rst = 1'b0;
    settle();
    check("post_rst_we", {31'd0, we_o}, 32'd0);
    check("post_rst_hold", {31'd0, hold_flag_o}, 32'd0);
    check("post_rst_assert", {31'd0, int_assert_o}, 32'd0);
    check("post_rst_data", data_o, 32'd0);
    step();

    // fresh ECALL after the abort
    inst_i = ECALL; inst_addr_i = 32'h130; csr_mtvec_i = 32'h280; csr_mstatus_i = 32'h0;
    d = cyc;
    push_wr(32'h341, 32'h130, d + 1);
    push_wr(32'h300, 32'h0, d + 2);
    push_wr(32'h342, 32'd11, d + 3);
    push_as(32'h280, d + 4);
    run_seq("ecall2", 4);

    repeat (3) step();
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
